// File: rtl/harris_gradient_window_gen.sv
// Harris gradient window generator: RGB565 raster in, per-channel 3x3 I_x/I_y windows out.
// Pipeline: accept -> gradient register -> window shift -> output register (window valid two edges after accept).
module harris_gradient_window_gen #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pixel_in,
    input  logic              pixel_valid,
    input  logic              frame_start,
    output logic signed [8:0] I_x_r [9],
    output logic signed [8:0] I_x_g [9],
    output logic signed [8:0] I_x_b [9],
    output logic signed [8:0] I_y_r [9],
    output logic signed [8:0] I_y_g [9],
    output logic signed [8:0] I_y_b [9],
    output logic              win_valid,
    output logic [15:0]       win_x,
    output logic [15:0]       win_y,
    output logic              win_last
);
    localparam int          XW      = $clog2(IMG_WIDTH);
    localparam logic [15:0] X_LAST  = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST  = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] CX_LAST = 16'(IMG_WIDTH - 3);
    localparam logic [15:0] CY_LAST = 16'(IMG_HEIGHT - 3);

    // Element order: [0..2] = I_x R,G,B ; [3..5] = I_y R,G,B
    typedef logic [5:0][8:0] grad_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [23:0] expand565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    function automatic logic [8:0] grad_diff(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [15:0] cur_x_s, cur_y_s;
    logic        accept_s, restart_s;

    // Frame state and raster position of the next expected pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Acceptance, raster advance and state transitions; frame_start always restarts at (0,0)
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        restart_s = pixel_valid && frame_start;
        cur_x_s   = restart_s ? 16'd0 : x_q;
        cur_y_s   = restart_s ? 16'd0 : y_q;
        case (state_q)
            ST_IDLE:   accept_s = restart_s;
            ST_ACTIVE: accept_s = pixel_valid;
            ST_DONE:   accept_s = restart_s;
            default:   accept_s = 1'b0;
        endcase
        if (accept_s) begin
            if (cur_x_s == X_LAST) begin
                x_d     = 16'd0;
                y_d     = cur_y_s + 16'd1;
                state_d = (cur_y_s == Y_LAST) ? ST_DONE : ST_ACTIVE;
            end else begin
                x_d     = cur_x_s + 16'd1;
                y_d     = cur_y_s;
                state_d = ST_ACTIVE;
            end
        end else if (state_q != ST_IDLE && state_q != ST_ACTIVE && state_q != ST_DONE) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    logic [23:0] pb1_q [IMG_WIDTH];
    logic [23:0] pb2_q [IMG_WIDTH];
    logic [23:0] cur_m1_q, r1_m1_q, r1_m2_q, r2_m1_q;
    logic [23:0] pix_s, pb1_rd_s, pb2_rd_s;
    grad_t       grad_s;

    // Gradient (x-1,y-1) from taps P(x,y-1), P(x-2,y-1), P(x-1,y), P(x-1,y-2)
    always_comb begin
        pix_s    = expand565(pixel_in);
        pb1_rd_s = pb1_q[cur_x_s[XW-1:0]];
        pb2_rd_s = pb2_q[cur_x_s[XW-1:0]];
        grad_s   = '0;
        for (int c = 0; c < 3; c++) begin
            grad_s[c]     = grad_diff(pb1_rd_s[23-8*c -: 8], r1_m2_q[23-8*c -: 8]);
            grad_s[c + 3] = grad_diff(cur_m1_q[23-8*c -: 8], r2_m1_q[23-8*c -: 8]);
        end
    end

    // Pixel line buffers (row y-1, row y-2) and column taps
    always_ff @(posedge clk) begin
        if (accept_s) begin
            pb1_q[cur_x_s[XW-1:0]] <= pix_s;
            pb2_q[cur_x_s[XW-1:0]] <= pb1_rd_s;
            cur_m1_q               <= pix_s;
            r1_m1_q                <= pb1_rd_s;
            r1_m2_q                <= r1_m1_q;
            r2_m1_q                <= pb2_rd_s;
        end
    end

    logic        g_vld_q;
    grad_t       g_q;
    logic [15:0] gx_q, gy_q;

    // Stage 1: registered gradient with its coordinates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_vld_q <= 1'b0;
            g_q     <= '0;
            gx_q    <= 16'd0;
            gy_q    <= 16'd0;
        end else begin
            g_vld_q <= accept_s && (cur_x_s >= 16'd2) && (cur_y_s >= 16'd2);
            if (accept_s) begin
                g_q  <= grad_s;
                gx_q <= cur_x_s - 16'd1;
                gy_q <= cur_y_s - 16'd1;
            end
        end
    end

    grad_t       gb1_q [IMG_WIDTH];
    grad_t       gb2_q [IMG_WIDTH];
    grad_t       win_q [9];
    grad_t       gb1_rd_s, gb2_rd_s;

    assign gb1_rd_s = gb1_q[gx_q[XW-1:0]];
    assign gb2_rd_s = gb2_q[gx_q[XW-1:0]];

    // Stage 2a: gradient line buffers and 3x3 window shift (newest column on the right)
    always_ff @(posedge clk) begin
        if (g_vld_q) begin
            gb1_q[gx_q[XW-1:0]] <= g_q;
            gb2_q[gx_q[XW-1:0]] <= gb1_rd_s;
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]     <= win_q[3*r + 1];
                win_q[3*r + 1] <= win_q[3*r + 2];
            end
            win_q[2] <= gb2_rd_s;
            win_q[5] <= gb1_rd_s;
            win_q[8] <= g_q;
        end
    end

    logic        pend_q, pend_last_q;
    logic [15:0] pend_x_q, pend_y_q;

    // Stage 2b: window-complete flag; a restart squashes anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_x_q    <= 16'd0;
            pend_y_q    <= 16'd0;
        end else begin
            pend_q      <= g_vld_q && (gx_q >= 16'd3) && (gy_q >= 16'd3) && !restart_s;
            pend_last_q <= ((gx_q - 16'd1) == CX_LAST) && ((gy_q - 16'd1) == CY_LAST);
            pend_x_q    <= gx_q - 16'd1;
            pend_y_q    <= gy_q - 16'd1;
        end
    end

    grad_t       out_q [9];
    logic        win_valid_q, win_last_q;
    logic [15:0] win_x_q, win_y_q;

    // Output registers: hold between strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_x_q     <= 16'd0;
            win_y_q     <= 16'd0;
            for (int i = 0; i < 9; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            win_valid_q <= pend_q && !restart_s;
            if (pend_q && !restart_s) begin
                win_last_q <= pend_last_q;
                win_x_q    <= pend_x_q;
                win_y_q    <= pend_y_q;
                for (int i = 0; i < 9; i++) begin
                    out_q[i] <= win_q[i];
                end
            end
        end
    end

    // Unpack output registers onto the per-channel window ports
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            I_x_r[i] = $signed(out_q[i][0]);
            I_x_g[i] = $signed(out_q[i][1]);
            I_x_b[i] = $signed(out_q[i][2]);
            I_y_r[i] = $signed(out_q[i][3]);
            I_y_g[i] = $signed(out_q[i][4]);
            I_y_b[i] = $signed(out_q[i][5]);
        end
    end

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;

endmodule

// File: tb/tb_harris_gradient_window_gen.sv
// Randomized self-checking bench for harris_gradient_window_gen (8x8 frames)
// against a frame-array reference model with a timed expectation queue.
module tb_harris_gradient_window_gen;
    localparam int W = 8;
    localparam int H = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       pixel_in;
    logic              pixel_valid;
    logic              frame_start;
    logic signed [8:0] I_x_r [9];
    logic signed [8:0] I_x_g [9];
    logic signed [8:0] I_x_b [9];
    logic signed [8:0] I_y_r [9];
    logic signed [8:0] I_y_g [9];
    logic signed [8:0] I_y_b [9];
    logic              win_valid;
    logic [15:0]       win_x;
    logic [15:0]       win_y;
    logic              win_last;

    harris_gradient_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .I_x_r(I_x_r), .I_x_g(I_x_g), .I_x_b(I_x_b),
        .I_y_r(I_y_r), .I_y_g(I_y_g), .I_y_b(I_y_b),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .win_last(win_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int               due;
        int               cx;
        int               cy;
        logic             last;
        logic [5:0][80:0] w;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          win_cnt  = 0;
    int          cur_mode = 0;
    bit          m_act    = 1'b0;
    int          mx = 0, my = 0;
    logic [23:0] fr [H][W];

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [23:0] exp565(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p) / 2048;
        g6 = (int'(p) / 32) % 64;
        b5 = int'(p) % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return 24'(r8 * 65536 + g8 * 256 + b8);
    endfunction

    function automatic int pc(input int x, input int y, input int c);
        return (int'(fr[y][x]) >> (16 - 8 * c)) % 256;
    endfunction

    function automatic logic [8:0] gd(input int a, input int b);
        int d;
        d = a - b;
        return 9'(d);
    endfunction

    function automatic logic [80:0] pk(input logic signed [8:0] a [9]);
        logic [80:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[9*i +: 9] = a[i];
        return v;
    endfunction

    function automatic logic [15:0] pat(input int mode, input int x, input int y);
        case (mode)
            0:       return 16'h0000;
            1:       return 16'h8410;
            2:       return (x >= 4) ? 16'hFFFF : 16'h0000;
            3:       return (x < 4) ? 16'hFFFF : 16'h0000;
            4:       return (y >= 4) ? 16'hF800 : 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Drop expected windows that would surface at or after the edge about to come
    task automatic squash_pending();
        while (q.size() > 0 && q[$].due >= cyc + 1) void'(q.pop_back());
    endtask

    task automatic model_px(input logic [15:0] pix, input bit fs);
        exp_t e;
        if (fs) begin
            squash_pending();
            m_act   = 1'b1;
            mx      = 0;
            my      = 0;
            win_cnt = 0;
        end else if (!m_act) begin
            return;
        end
        fr[my][mx] = exp565(pix);
        if (mx >= 4 && my >= 4) begin
            e.due  = cyc + 3;
            e.cx   = mx - 2;
            e.cy   = my - 2;
            e.last = (e.cx == W - 3) && (e.cy == H - 3);
            e.w    = '0;
            for (int i = 0; i < 9; i++) begin
                int x, y;
                x = e.cx + i % 3 - 1;
                y = e.cy + i / 3 - 1;
                for (int c = 0; c < 3; c++) begin
                    e.w[c][9*i +: 9]     = gd(pc(x + 1, y, c), pc(x - 1, y, c));
                    e.w[c + 3][9*i +: 9] = gd(pc(x, y + 1, c), pc(x, y - 1, c));
                end
            end
            q.push_back(e);
        end
        if (mx == W - 1) begin
            mx = 0;
            if (my == H - 1) m_act = 1'b0;
            else my++;
        end else begin
            mx++;
        end
    endtask

    task automatic drive_px(input logic [15:0] pix, input bit fs, input int gap);
        for (int i = 0; i < gap; i++) begin
            pixel_valid = 1'b0;
            frame_start = 1'b0;
            pixel_in    = 16'($urandom);
            @(posedge clk); #1;
        end
        pixel_in    = pix;
        frame_start = fs;
        pixel_valid = 1'b1;
        model_px(pix, fs);
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int maxgap, input int npx);
        cur_mode = mode;
        for (int p = 0; p < npx; p++) begin
            drive_px(pat(mode, p % W, p / W), p == 0,
                     (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
    endtask

    task automatic finish_frame(input string tag);
        repeat (6) @(posedge clk);
        #1;
        check_val(tag, win_cnt, 16);
    endtask

    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        squash_pending();
        m_act = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val({tag, "_valid"}, win_valid, 1'b0);
        check_val({tag, "_last"}, win_last, 1'b0);
        check_val({tag, "_xy"}, {win_x, win_y}, 32'd0);
        check_val({tag, "_ix"}, {pk(I_x_r), pk(I_x_g), pk(I_x_b)}, 243'd0);
        check_val({tag, "_iy"}, {pk(I_y_r), pk(I_y_g), pk(I_y_b)}, 243'd0);
    endtask

    // Scoreboard: every strobe must match the head of the expectation queue on its due cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            check_val("missed_window", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (win_valid) begin
            win_cnt++;
            if (q.size() == 0) begin
                check_val("spurious_valid", 1'b1, 1'b0);
            end else begin
                mon_e = q.pop_front();
                check_val("latency", cyc, mon_e.due);
                check_val("win_x", win_x, 16'(mon_e.cx));
                check_val("win_y", win_y, 16'(mon_e.cy));
                check_val("win_last", win_last, mon_e.last);
                check_val("I_x_r", pk(I_x_r), mon_e.w[0]);
                check_val("I_x_g", pk(I_x_g), mon_e.w[1]);
                check_val("I_x_b", pk(I_x_b), mon_e.w[2]);
                check_val("I_y_r", pk(I_y_r), mon_e.w[3]);
                check_val("I_y_g", pk(I_y_g), mon_e.w[4]);
                check_val("I_y_b", pk(I_y_b), mon_e.w[5]);
                if (cur_mode == 2 && win_x == 16'd3) begin
                    check_val("vedge_ix_r1", $unsigned(I_x_r[1]), 9'd255);
                    check_val("vedge_ix_g5", $unsigned(I_x_g[5]), 9'd255);
                    check_val("vedge_ix_b8", $unsigned(I_x_b[8]), 9'd255);
                    check_val("vedge_ix_r0", $unsigned(I_x_r[0]), 9'd0);
                    check_val("vedge_iy_g4", $unsigned(I_y_g[4]), 9'd0);
                end
                if (cur_mode == 3 && win_x == 16'd3) begin
                    check_val("iedge_ix_g4", $unsigned(I_x_g[4]), 9'h101);
                    check_val("iedge_ix_r6", $unsigned(I_x_r[6]), 9'd0);
                end
                if (cur_mode == 4 && win_y == 16'd3) begin
                    check_val("hedge_iy_r3", $unsigned(I_y_r[3]), 9'd255);
                    check_val("hedge_iy_r8", $unsigned(I_y_r[8]), 9'd255);
                    check_val("hedge_iy_r0", $unsigned(I_y_r[0]), 9'd0);
                    check_val("hedge_iy_g4", $unsigned(I_y_g[4]), 9'd0);
                    check_val("hedge_ix_r4", $unsigned(I_x_r[4]), 9'd0);
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        pixel_in    = 16'd0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        send_frame(0, 0, W * H); finish_frame("count_flat0");
        send_frame(1, 0, W * H); finish_frame("count_flat8410");
        send_frame(2, 0, W * H); finish_frame("count_vedge");
        send_frame(3, 0, W * H); finish_frame("count_iedge");
        send_frame(4, 0, W * H); finish_frame("count_hedge");
        send_frame(2, 3, W * H); finish_frame("count_vedge_gaps");
        for (int f = 0; f < 3; f++) begin
            send_frame(5, (f == 0) ? 0 : 3, W * H);
            finish_frame("count_random");
        end

        // Abort: frame_start lands on what would have been pixel (5,5)
        send_frame(5, 1, 5 * W + 5);
        send_frame(5, 0, W * H); finish_frame("count_after_abort");

        // One-cycle reset mid-frame, then pixels without frame_start are ignored
        send_frame(5, 0, 30);
        do_reset("midreset");
        for (int i = 0; i < 12; i++) drive_px(16'($urandom), 1'b0, 0);
        send_frame(5, 2, W * H); finish_frame("count_after_reset");

        // Trailing pixels after the final pixel, no frame_start
        for (int i = 0; i < 20; i++) drive_px(16'($urandom), 1'b0, 0);
        repeat (6) @(posedge clk);
        #1;
        check_val("trailing_no_windows", win_cnt, 16);
        check_val("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/harris_gradient_window_gen.md
Name: harris_gradient_window_gen

Overview:
- Upstream feeder for the Harris corner detector.
- Consumes a raster RGB565 pixel stream and computes per-channel central-difference gradients I_x and I_y, each 9-bit signed.
- Buffers the gradients and emits, per pixel, the 3x3 gradient window for each of R, G and B, in the array form the corner detector takes as input.
- Sits between the camera/frame-capture stream and the corner detector.

Parameters:
- IMG_WIDTH, 320, pixels per line (min 5).
- IMG_HEIGHT, 240, lines per frame (min 5).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- pixel_in  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- pixel_valid  in  1  pixel_in is valid this cycle; no backpressure.
- frame_start  in  1  qualified by pixel_valid; marks pixel (0,0).
- I_x_r, I_x_g, I_x_b, I_y_r, I_y_g, I_y_b  out  signed [8:0] x [8:0] each  3x3 gradient windows, row-major; [0]=(cx-1,cy-1), [4]=centre, [8]=(cx+1,cy+1).
- win_valid  out  1  windows valid this cycle (single-cycle strobe).
- win_x  out  16  window centre column cx.
- win_y  out  16  window centre row cy.
- win_last  out  1  with win_valid, marks the last window of the frame.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - all outputs 0; win_valid=0; win_last=0.
  - x/y counters 0; state IDLE.
  - Line buffer contents need not be cleared.
- States:
  - IDLE: pixels ignored until pixel_valid & frame_start. That pixel is (0,0); go to ACTIVE.
  - ACTIVE: each pixel_valid advances x. At x=IMG_WIDTH-1, x wraps to 0 and y increments. Accepting (IMG_WIDTH-1, IMG_HEIGHT-1) goes to DONE.
  - DONE: pixels ignored until pixel_valid & frame_start, which restarts at (0,0) in ACTIVE.
  - pixel_valid & frame_start in any state (including mid-frame ACTIVE) aborts the current frame and treats that pixel as (0,0). Pending in-flight windows of the aborted frame are squashed.
- Channel expansion to 8 bit: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Gradients:
  - I_x(cx,cy)=P(cx+1,cy)-P(cx-1,cy); I_y(cx,cy)=P(cx,cy+1)-P(cx,cy-1).
  - Computed as {1'b0,a}-{1'b0,b}, range -255..+255, no saturation needed.
  - Defined for cx in 1..W-2, cy in 1..H-2. Gradient (x-1,y-1) is formed when pixel (x,y) is accepted, for x>=2, y>=2.
- Buffering:
  - Two pixel line buffers (depth IMG_WIDTH, 24 bit).
  - Two gradient line buffers per channel, holding I_x and I_y.
  - 3x3 shift registers for the window.
- Window emission:
  - A window centred at (cx,cy) is emitted only for cx in 2..W-3, cy in 2..H-3.
  - Emission is triggered by accepting pixel (cx+2, cy+2).
  - (IMG_WIDTH-4)*(IMG_HEIGHT-4) windows per frame.
  - No windows straddle a line wrap or use data from rows/columns outside the frame.
- Latency: pixel accepted at edge k -> win_valid=1 and window data/coordinates valid after edge k+2. Constant regardless of idle gaps.
- Output hold: between strobes, window outputs hold their last values and win_valid=0.
- Idle cycles: pixel_valid=0 cycles may occur anywhere, including mid-line. Pipeline stages advance only with accepted pixels; outputs already in the 2-stage pipeline still drain on schedule.
- win_last: asserted with the window at (W-3, H-3).

Test Plan (IMG_WIDTH=IMG_HEIGHT=8 unless stated):
- Flat frame, all pixels 16'h0000, then a frame of 16'h8410 -> exactly 16 windows per frame; all 54 window elements 0; win_x/win_y step 2..5 row-major; win_last only on (5,5).
- Vertical edge, pixel=16'hFFFF for x>=4 else 0 -> window at cx=3: I_x_* indices 1,2,4,5,7,8 = +255 and 0,3,6 = 0; all I_y_*=0.
- Inverted edge, pixel=16'hFFFF for x<4 -> same indices = -255 (9'h101).
- Horizontal edge on R only, pixel=16'hF800 for y>=4 -> at cy=3 I_y_r indices 3..8 = +255, I_y_g/I_y_b = 0, all I_x = 0.
- Vertical-edge frame with 0-3 random idle cycles between pixels -> window sequence identical to gap-free run; each win_valid exactly 2 cycles after its triggering pixel.
- frame_start at pixel (5,5) mid-frame -> no windows from the aborted frame after that pixel; new frame yields 16 windows.
- rst_n low for 1 cycle mid-frame -> win_valid=0 next cycle; pixels ignored until frame_start.
- Pixels after the final pixel without frame_start -> no output.
